// File: rtl/pkt_hdr_sequencer.sv
// Header-parse sequencer: beat framing, IP_DST word strobes, pending-result tracking with lost-result timeout.
// Optional statistics counters are built when PKT_SEQ_STATS_EN is defined.
module pkt_hdr_sequencer #(
  parameter int MAX_PENDING  = 4,
  parameter int INFO_TIMEOUT = 16
) (
  input  logic        axi_aclk,
  input  logic        axi_resetn,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        word_IP_DST_HI,
  output logic        word_IP_DST_LO,
  output logic        stall_req,
  input  logic        eth_parser_info_vld,
  output logic        eth_parser_rd_info,
  output logic        hdr_info_vld,
  input  logic        hdr_info_rd,
  output logic [2:0]  pending_cnt,
  output logic        timeout_err,
  output logic        overflow_err,
  output logic [31:0] pkt_count,
  output logic [15:0] timeout_count
);

  localparam logic [2:0] MAX_P   = 3'(MAX_PENDING);
  localparam logic [7:0] TO_LAST = 8'(INFO_TIMEOUT - 1);

  typedef enum logic {SOP = 1'b0, IN_PKT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_word_cnt;
  logic [2:0]  r_pending;
  logic [7:0]  r_timer;
  logic        r_stall;
  logic        r_timeout_err;
  logic        r_overflow;
  logic        w_beat;
  logic        w_run;
  logic        w_timeout;
  logic        w_inc;
  logic        w_dec;

  assign w_beat = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) r_state <= SOP;
    else             r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SOP:     if (w_beat && !s_axis_tlast) w_state_next = IN_PKT;
      IN_PKT:  if (w_beat && s_axis_tlast)  w_state_next = SOP;
      default: w_state_next = SOP;
    endcase
  end

  // Strobes are gated by reset so nothing leaks out while the block is held in reset.
  always_comb begin
    word_IP_DST_HI = 1'b0;
    word_IP_DST_LO = 1'b0;
    case (r_state)
      SOP:     word_IP_DST_HI = w_beat & axi_resetn;
      IN_PKT:  word_IP_DST_LO = w_beat & (r_word_cnt == 8'd1) & axi_resetn;
      default: ;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_word_cnt <= '0;
    end else if (w_beat) begin
      if (s_axis_tlast)              r_word_cnt <= '0;
      else if (r_word_cnt != 8'hFF)  r_word_cnt <= r_word_cnt + 8'd1;
    end
  end

  assign hdr_info_vld       = eth_parser_info_vld & (r_pending != 3'd0);
  assign eth_parser_rd_info = hdr_info_vld & hdr_info_rd;

  assign w_run     = (r_pending != 3'd0) & ~eth_parser_info_vld;
  assign w_timeout = w_run & (r_timer == TO_LAST);
  assign w_inc     = word_IP_DST_HI;
  assign w_dec     = eth_parser_rd_info | w_timeout;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_pending     <= '0;
      r_timer       <= '0;
      r_stall       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_inc && !w_dec) begin
        if (r_pending != MAX_P) r_pending <= r_pending + 3'd1;
      end else if (!w_inc && w_dec && r_pending != 3'd0) begin
        r_pending <= r_pending - 3'd1;
      end
      if (w_inc && r_pending == MAX_P) r_overflow <= 1'b1;
      // A pop implies info valid, so it already stops the timer via w_run.
      if (!w_run || w_timeout) r_timer <= '0;
      else                     r_timer <= r_timer + 8'd1;
      r_stall       <= (r_pending == MAX_P);
      r_timeout_err <= w_timeout;
    end
  end

  assign pending_cnt  = r_pending;
  assign stall_req    = r_stall;
  assign timeout_err  = r_timeout_err;
  assign overflow_err = r_overflow;

`ifdef PKT_SEQ_STATS_EN
  logic [31:0] r_pkt_count;
  logic [15:0] r_timeout_count;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_pkt_count     <= '0;
      r_timeout_count <= '0;
    end else begin
      if (word_IP_DST_HI) r_pkt_count <= r_pkt_count + 32'd1;
      if (w_timeout && r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 16'd1;
    end
  end

  assign pkt_count     = r_pkt_count;
  assign timeout_count = r_timeout_count;
`else
  assign pkt_count     = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_pkt_hdr_sequencer.sv
// Directed bench for pkt_hdr_sequencer with MAX_PENDING=4, INFO_TIMEOUT=16.
// Expected statistics values follow PKT_SEQ_STATS_EN.
module tb_pkt_hdr_sequencer;

`ifdef PKT_SEQ_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tvalid, tready, tlast;
  logic        hi, lo, stall;
  logic        info_vld, rd_info, hdr_vld, hdr_rd;
  logic [2:0]  pending;
  logic        to_err, ov_err;
  logic [31:0] pkt_cnt;
  logic [15:0] to_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pkt_hdr_sequencer #(.MAX_PENDING(4), .INFO_TIMEOUT(16)) dut (
    .axi_aclk            (clk),
    .axi_resetn          (rst_n),
    .s_axis_tvalid       (tvalid),
    .s_axis_tready       (tready),
    .s_axis_tlast        (tlast),
    .word_IP_DST_HI      (hi),
    .word_IP_DST_LO      (lo),
    .stall_req           (stall),
    .eth_parser_info_vld (info_vld),
    .eth_parser_rd_info  (rd_info),
    .hdr_info_vld        (hdr_vld),
    .hdr_info_rd         (hdr_rd),
    .pending_cnt         (pending),
    .timeout_err         (to_err),
    .overflow_err        (ov_err),
    .pkt_count           (pkt_cnt),
    .timeout_count       (to_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic rdy, input logic l, input logic iv, input logic rd);
    tvalid   = v;
    tready   = rdy;
    tlast    = l;
    info_vld = iv;
    hdr_rd   = rd;
    #2;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0);
    nxt(); nxt();
    chk("rst_hi", 32'(hi), 0);
    chk("rst_lo", 32'(lo), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_overflow", 32'(ov_err), 0);
    chk("rst_timeout", 32'(to_err), 0);
    chk("rst_hdr_vld", 32'(hdr_vld), 0);
    chk("rst_pkt_count", pkt_cnt, 0);
    chk("rst_timeout_count", 32'(to_cnt), 0);
    rst_n = 1'b1;
    nxt();

    // 3-beat packet, info arrives on beat 2 and is consumed at once
    drv(1, 0, 0, 0, 1);
    chk("t1_no_beat_hi", 32'(hi), 0);
    nxt();
    drv(1, 1, 0, 0, 1);
    chk("t1_b0_hi", 32'(hi), 1);
    chk("t1_b0_lo", 32'(lo), 0);
    chk("t1_b0_hdr_vld", 32'(hdr_vld), 0);
    nxt();
    drv(1, 1, 0, 0, 1);
    chk("t1_b1_pending", 32'(pending), 1);
    chk("t1_b1_hi", 32'(hi), 0);
    chk("t1_b1_lo", 32'(lo), 1);
    nxt();
    drv(1, 1, 1, 1, 1);
    chk("t1_b2_lo", 32'(lo), 0);
    chk("t1_b2_hdr_vld", 32'(hdr_vld), 1);
    chk("t1_b2_rd_info", 32'(rd_info), 1);
    chk("t1_b2_pending", 32'(pending), 1);
    nxt();
    drv(0, 1, 0, 1, 1);
    chk("t1_after_pending", 32'(pending), 0);
    chk("t1_after_rd_info", 32'(rd_info), 0);
    chk("t1_after_hdr_vld", 32'(hdr_vld), 0);
    nxt();

    // five single-beat packets with no parser info: saturation, stall, overflow
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 1, 0, 0);
      chk($sformatf("t2_hi_%0d", i), 32'(hi), 1);
      chk($sformatf("t2_pending_%0d", i), 32'(pending), 32'(i));
      chk($sformatf("t2_stall_%0d", i), 32'(stall), 0);
      chk($sformatf("t2_overflow_%0d", i), 32'(ov_err), 0);
      nxt();
    end
    drv(0, 1, 0, 0, 0);
    chk("t2_sat_pending", 32'(pending), 4);
    chk("t2_sat_stall", 32'(stall), 1);
    chk("t2_sat_overflow", 32'(ov_err), 1);
    nxt();
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 1, 1);
      chk($sformatf("t2_drain_rd_%0d", i), 32'(rd_info), 1);
      chk($sformatf("t2_drain_pending_%0d", i), 32'(pending), 32'(4 - i));
      chk($sformatf("t2_drain_stall_%0d", i), 32'(stall), (i < 2) ? 32'd1 : 32'd0);
      nxt();
    end
    drv(0, 1, 0, 0, 0);
    chk("t2_empty_pending", 32'(pending), 0);
    nxt();

    // lost result: timeout 16 cycles after pending became 1
    drv(1, 1, 1, 0, 0);
    chk("t3_hi", 32'(hi), 1);
    nxt();
    drv(0, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t3_wait_timeout_%0d", k), 32'(to_err), 0);
      chk($sformatf("t3_wait_pending_%0d", k), 32'(pending), 1);
      nxt();
    end
    chk("t3_timeout_pulse", 32'(to_err), 1);
    chk("t3_timeout_pending", 32'(pending), 0);
    chk("t3_timeout_count", 32'(to_cnt), STATS_EN ? 32'd1 : 32'd0);
    chk("t3_pkt_count", pkt_cnt, STATS_EN ? 32'd7 : 32'd0);
    nxt();
    chk("t3_timeout_single", 32'(to_err), 0);

    // beat 0 of a new packet coincides with a pop at pending=2
    drv(1, 1, 1, 0, 0);
    nxt();
    drv(1, 1, 1, 0, 0);
    nxt();
    drv(1, 1, 0, 1, 1);
    chk("t4_pending_before", 32'(pending), 2);
    chk("t4_hi", 32'(hi), 1);
    chk("t4_rd_info", 32'(rd_info), 1);
    nxt();
    drv(1, 1, 1, 0, 0);
    chk("t4_pending_same", 32'(pending), 2);
    chk("t4_b1_hi", 32'(hi), 0);
    chk("t4_b1_lo", 32'(lo), 1);
    nxt();
    drv(0, 1, 0, 1, 1);
    chk("t4_drain0", 32'(pending), 2);
    nxt();
    drv(0, 1, 0, 1, 1);
    chk("t4_drain1", 32'(pending), 1);
    nxt();
    drv(0, 1, 0, 0, 0);
    chk("t4_empty", 32'(pending), 0);
    chk("t4_overflow_sticky", 32'(ov_err), 1);
    chk("t4_pkt_count", pkt_cnt, STATS_EN ? 32'd10 : 32'd0);
    nxt();

    // reset asserted during beat 1 of a 4-beat packet, then a fresh packet
    drv(1, 1, 0, 0, 0);
    chk("t5_b0_hi", 32'(hi), 1);
    nxt();
    rst_n = 1'b0;
    drv(1, 1, 0, 0, 0);
    chk("t5_rst_hi", 32'(hi), 0);
    chk("t5_rst_lo", 32'(lo), 0);
    chk("t5_rst_pending", 32'(pending), 0);
    chk("t5_rst_overflow", 32'(ov_err), 0);
    chk("t5_rst_stall", 32'(stall), 0);
    chk("t5_rst_pkt_count", pkt_cnt, 0);
    nxt();
    chk("t5_rst_hi_hold", 32'(hi), 0);
    nxt();
    rst_n = 1'b1;
    drv(1, 1, 0, 0, 0);
    chk("t5_rel_hi", 32'(hi), 1);
    chk("t5_rel_lo", 32'(lo), 0);
    nxt();
    drv(1, 1, 0, 0, 0);
    chk("t5_rel_b1_hi", 32'(hi), 0);
    chk("t5_rel_b1_lo", 32'(lo), 1);
    chk("t5_rel_pending", 32'(pending), 1);
    nxt();
    drv(1, 1, 1, 0, 0);
    chk("t5_rel_b2_lo", 32'(lo), 0);
    nxt();
    drv(0, 1, 0, 1, 1);
    chk("t5_pop", 32'(rd_info), 1);
    nxt();
    drv(0, 1, 0, 0, 0);
    chk("t5_empty", 32'(pending), 0);
    nxt();

    // ten single-beat packets, each overlapping a pop of the previous result
    for (int i = 0; i < 10; i++) begin
      drv(1, 1, 1, 1, 1);
      chk($sformatf("t6_hi_%0d", i), 32'(hi), 1);
      chk($sformatf("t6_pending_%0d", i), 32'(pending), (i == 0) ? 32'd0 : 32'd1);
      nxt();
    end
    drv(0, 1, 0, 1, 1);
    chk("t6_last_pending", 32'(pending), 1);
    nxt();
    drv(0, 0, 0, 0, 0);
    chk("t6_empty", 32'(pending), 0);
    chk("t6_pkt_count", pkt_cnt, STATS_EN ? 32'd11 : 32'd0);
    chk("t6_timeout_count", 32'(to_cnt), 0);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
